// File: rtl/des_search_pkg.sv
// Shared types and defaults for the DES key-search controller.
package des_search_pkg;

    localparam int KEY_W_DEF   = 56;
    localparam int DES_LAT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } search_state_e;

    // One in-flight candidate: raw key plus a flag saying the slot holds a real issue.
    typedef struct packed {
        logic                 valid;
        logic [KEY_W_DEF-1:0] key;
    } dl_entry_t;

endpackage

// File: rtl/des_key_expand.sv
// Expands a 56-bit raw key into a 64-bit DES key: each 7-bit slice becomes the
// upper seven bits of a byte whose LSB makes the byte odd parity.
module des_key_expand
    import des_search_pkg::*;
(
    input  logic [KEY_W_DEF-1:0] raw_i,
    output logic [63:0]          key_o
);

    always_comb begin
        key_o = '0;
        for (int i = 0; i < 8; i++) begin
            key_o[8*i+1 +: 7] = raw_i[7*i +: 7];
            key_o[8*i]        = ~^raw_i[7*i +: 7];
        end
    end

endmodule

// File: rtl/des_search_ctrl.sv
// Brute-force DES key-range search sequencer with in-flight key tracking.
// Define DES_SEARCH_PERF_EN to add the keys_tested counter output.
module des_search_ctrl
    import des_search_pkg::*;
#(
    parameter int KEY_W   = KEY_W_DEF,
    parameter int DES_LAT = DES_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] start_key,
    input  logic [KEY_W-1:0] end_key,
    input  logic [63:0]      plaintext,
    input  logic [63:0]      target_ct,
    output logic [63:0]      des_key,
    output logic [63:0]      des_pt,
    output logic             des_in_valid,
    input  logic [63:0]      des_ct,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [63:0]      found_key,
    output logic [KEY_W-1:0] cur_count
`ifdef DES_SEARCH_PERF_EN
    ,
    output logic [KEY_W:0]   keys_tested
`endif
);

    search_state_e    state_q, state_d;
    logic [KEY_W-1:0] cur_q, cur_d;
    logic [KEY_W-1:0] end_q, end_d;
    logic [63:0]      pt_q, pt_d;
    logic [63:0]      tgt_q, tgt_d;
    logic [63:0]      fkey_q, fkey_d;
    logic             found_q, found_d;
    dl_entry_t        dl_q [DES_LAT];
    dl_entry_t        dl_d [DES_LAT];

    dl_entry_t        head;
    logic             run, active, match, pending, flush;
    logic [63:0]      cand_key, head_key;

    assign run    = (state_q == RUN);
    assign active = run || (state_q == DRAIN);
    assign head   = dl_q[DES_LAT-1];
    assign match  = active && head.valid && (des_ct == tgt_q);

    des_key_expand u_cand_expand (
        .raw_i (cur_q),
        .key_o (cand_key)
    );

    des_key_expand u_found_expand (
        .raw_i (head.key),
        .key_o (head_key)
    );

    // Anything still in flight behind the head keeps DRAIN alive.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DES_LAT - 1; i++) begin
            pending = pending | dl_q[i].valid;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        end_d   = end_q;
        pt_d    = pt_q;
        tgt_d   = tgt_q;
        found_d = found_q;
        fkey_d  = fkey_q;
        flush   = 1'b0;

        dl_d[0] = '{valid: run, key: cur_q};
        for (int i = 1; i < DES_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end

        if (abort) begin
            state_d = IDLE;
            found_d = 1'b0;
            fkey_d  = '0;
            flush   = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        cur_d   = start_key;
                        end_d   = end_key;
                        pt_d    = plaintext;
                        tgt_d   = target_ct;
                        found_d = 1'b0;
                        fkey_d  = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (cur_q == end_q) begin
                        state_d = DRAIN;
                    end else begin
                        cur_d = cur_q + KEY_W'(1);
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // The head is always the oldest outstanding key, so the first hit seen is the lowest issued.
            if (match) begin
                state_d = DONE;
                found_d = 1'b1;
                fkey_d  = head_key;
            end
            if (state_d == DONE) begin
                flush = 1'b1;
            end
        end

        if (flush) begin
            for (int i = 0; i < DES_LAT; i++) begin
                dl_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            end_q   <= '0;
            pt_q    <= '0;
            tgt_q   <= '0;
            found_q <= 1'b0;
            fkey_q  <= '0;
            for (int i = 0; i < DES_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            pt_q    <= pt_d;
            tgt_q   <= tgt_d;
            found_q <= found_d;
            fkey_q  <= fkey_d;
            for (int i = 0; i < DES_LAT; i++) begin
                dl_q[i] <= dl_d[i];
            end
        end
    end

`ifdef DES_SEARCH_PERF_EN
    logic [KEY_W:0] tested_q, tested_d;

    always_comb begin
        tested_d = tested_q;
        if (!abort) begin
            if ((state_q == IDLE || state_q == DONE) && start) begin
                tested_d = '0;
            end else if (active && head.valid) begin
                tested_d = tested_q + (KEY_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tested_q <= '0;
        end else begin
            tested_q <= tested_d;
        end
    end

    assign keys_tested = tested_q;
`endif

    // Gated so the engine sees an all-zero key whenever nothing is being issued.
    assign des_key      = run ? cand_key : '0;
    assign des_pt       = pt_q;
    assign des_in_valid = run;
    assign busy         = active;
    assign done         = (state_q == DONE);
    assign found        = found_q;
    assign found_key    = fkey_q;
    assign cur_count    = cur_q;

endmodule
